// File: rtl/cp0_excp_pkg.sv
// CP0 exception block: register numbers, exception codes, Status/Cause field
// positions, the decoded MEM-stage flag layout and the exception priority encoder.
package cp0_excp_pkg;

  // CP0 register numbers reachable by mtc0/mfc0
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Encoded exception types handed to ctrl
  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Status field positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_IPSW_HI = 9;
  localparam int CAUSE_IPHW_LO = 10;
  localparam int CAUSE_IP_HI   = 15;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_BD      = 31;

  // MEM-stage exception flags, MSB first so the struct overlays the raw 9-bit bus
  typedef struct packed {
    logic ades;
    logic adel_d;
    logic eret;
    logic bp;
    logic sys;
    logic tr;
    logic ov;
    logic ri;
    logic adel_if;
  } exc_flags_t;

  // Fixed-priority pick of the exception source; interrupts outrank everything
  function automatic logic [31:0] exc_encode(input logic int_req, input exc_flags_t f);
    logic [31:0] code;
    code = EXC_NONE;
    if (int_req)        code = EXC_INT;
    else if (f.adel_if) code = EXC_ADEL;
    else if (f.ri)      code = EXC_RI;
    else if (f.ov)      code = EXC_OV;
    else if (f.tr)      code = EXC_TR;
    else if (f.sys)     code = EXC_SYS;
    else if (f.bp)      code = EXC_BP;
    else if (f.adel_d)  code = EXC_ADEL;
    else if (f.ades)    code = EXC_ADES;
    else if (f.eret)    code = EXC_ERET;
    return code;
  endfunction

endpackage

// File: rtl/cp0_excp.sv
// CP0 exception source: holds BadVAddr/Count/Compare/Status/Cause/EPC, prioritises
// MEM-stage exceptions and interrupts, and commits exception state on the flush edge.
module cp0_excp #(
  parameter int          MEM_STALL_BIT = 5,
  parameter logic [31:0] STATUS_RST    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [8:0]  stall,
  input  logic [5:0]  ext_int,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_ds,
  input  logic [8:0]  mem_exc_flags,
  input  logic [31:0] mem_fetch_va,
  input  logic [31:0] mem_data_va,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_epc_o,
  output logic        timer_int_o
);
  import cp0_excp_pkg::*;

  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        r_tick;

  exc_flags_t  w_flags;
  logic        w_int_req;
  logic [31:0] w_excepttype;
  logic        w_exc_commit;
  logic        w_sync_exc;
  logic        w_eret;
  logic        w_addr_exc;
  logic        w_first_exc;
  logic [4:0]  w_exc_code;
  logic        w_mtc0;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_count_hit;
  logic [31:0] w_exc_epc;
  logic [31:0] w_bad_va;

  assign w_flags   = exc_flags_t'(mem_exc_flags);
  // Pending interrupt only when enabled, not already in exception level, and unmasked
  assign w_int_req = r_status[STATUS_IE] & ~r_status[STATUS_EXL] &
                     (|(r_cause[CAUSE_IP_HI:CAUSE_IP_LO] & r_status[STATUS_IM_HI:STATUS_IM_LO]));

  assign w_excepttype = mem_valid ? exc_encode(w_int_req, w_flags) : EXC_NONE;
  assign w_exc_commit = (w_excepttype != EXC_NONE);
  assign w_eret       = (w_excepttype == EXC_ERET);
  assign w_sync_exc   = w_exc_commit & ~w_eret;
  assign w_addr_exc   = (w_excepttype == EXC_ADEL) | (w_excepttype == EXC_ADES);
  // EPC and BD are only captured for the outermost exception
  assign w_first_exc  = w_sync_exc & ~r_status[STATUS_EXL];
  // Interrupts record ExcCode 0; every other source records its own code
  assign w_exc_code   = (w_excepttype == EXC_INT) ? 5'd0 : w_excepttype[4:0];
  assign w_exc_epc    = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
  // adel_if can only be the winning address error when its own flag is set
  assign w_bad_va     = w_flags.adel_if ? mem_fetch_va : mem_data_va;

  // An mtc0 lands only from a live, unstalled MEM instruction that is not being flushed
  assign w_mtc0       = cp0_we & mem_valid & ~stall[MEM_STALL_BIT] & ~w_exc_commit;
  assign w_wr_count   = w_mtc0 & (cp0_waddr == CP0_COUNT);
  assign w_wr_compare = w_mtc0 & (cp0_waddr == CP0_COMPARE);
  assign w_wr_status  = w_mtc0 & (cp0_waddr == CP0_STATUS);
  assign w_wr_cause   = w_mtc0 & (cp0_waddr == CP0_CAUSE);
  assign w_wr_epc     = w_mtc0 & (cp0_waddr == CP0_EPC);

  assign w_count_hit  = (r_count == r_compare) & (r_compare != 32'd0);

  // Half-rate tick and Count: an mtc0 Count replaces the increment but leaves the tick phase alone
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick  <= 1'b0;
      r_count <= 32'd0;
    end else begin
      r_tick <= ~r_tick;
      if (w_wr_count) r_count <= cp0_wdata;
      else if (r_tick) r_count <= r_count + 32'd1;
    end
  end

  // Compare register, written only by mtc0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_compare <= 32'd0;
    else if (w_wr_compare) r_compare <= cp0_wdata;
  end

  // Status: exception entry sets EXL, eret clears it, mtc0 touches IM/EXL/IE only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status <= STATUS_RST;
    end else if (w_sync_exc) begin
      r_status[STATUS_EXL] <= 1'b1;
    end else if (w_eret) begin
      r_status[STATUS_EXL] <= 1'b0;
    end else if (w_wr_status) begin
      r_status[STATUS_IM_HI:STATUS_IM_LO] <= cp0_wdata[STATUS_IM_HI:STATUS_IM_LO];
      r_status[STATUS_EXL]                <= cp0_wdata[STATUS_EXL];
      r_status[STATUS_IE]                 <= cp0_wdata[STATUS_IE];
    end
  end

  // Cause: hardware IP sampled every cycle, TI from the timer, software IP by mtc0, BD/ExcCode on exception
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause <= 32'd0;
    end else begin
      r_cause[CAUSE_IP_HI:CAUSE_IPHW_LO] <= {ext_int[5] | r_cause[CAUSE_TI], ext_int[4:0]};
      if (w_wr_compare) r_cause[CAUSE_TI] <= 1'b0;
      else if (w_count_hit) r_cause[CAUSE_TI] <= 1'b1;
      if (w_wr_cause) r_cause[CAUSE_IPSW_HI:CAUSE_IP_LO] <= cp0_wdata[CAUSE_IPSW_HI:CAUSE_IP_LO];
      if (w_first_exc) r_cause[CAUSE_BD] <= mem_in_ds;
      if (w_sync_exc) r_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= w_exc_code;
    end
  end

  // EPC: captured on outermost exception entry, otherwise writable by mtc0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_epc <= 32'd0;
    else if (w_first_exc) r_epc <= w_exc_epc;
    else if (w_wr_epc) r_epc <= cp0_wdata;
  end

  // BadVAddr: loaded by address-error exceptions only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_badvaddr <= 32'd0;
    else if (w_sync_exc & w_addr_exc) r_badvaddr <= w_bad_va;
  end

  // mfc0 read mux over the registered state
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = r_badvaddr;
      CP0_COUNT:    cp0_rdata = r_count;
      CP0_COMPARE:  cp0_rdata = r_compare;
      CP0_STATUS:   cp0_rdata = r_status;
      CP0_CAUSE:    cp0_rdata = r_cause;
      CP0_EPC:      cp0_rdata = r_epc;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  assign excepttype_o = w_excepttype;
  assign cp0_epc_o    = r_epc;
  assign timer_int_o  = r_cause[CAUSE_TI];

endmodule

// File: tb/tb_cp0_excp.sv
// Directed bench for cp0_excp: expected values queued at stimulus time, popped when observed.
module tb_cp0_excp;

  logic        clk;
  logic        resetn;
  logic [8:0]  stall;
  logic [5:0]  ext_int;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_ds;
  logic [8:0]  mem_exc_flags;
  logic [31:0] mem_fetch_va;
  logic [31:0] mem_data_va;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] excepttype_o;
  logic [31:0] cp0_epc_o;
  logic        timer_int_o;

  cp0_excp #(.MEM_STALL_BIT(5), .STATUS_RST(32'h0040_0000)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .ext_int(ext_int),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_ds(mem_in_ds),
    .mem_exc_flags(mem_exc_flags), .mem_fetch_va(mem_fetch_va), .mem_data_va(mem_data_va),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .excepttype_o(excepttype_o), .cp0_epc_o(cp0_epc_o), .timer_int_o(timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_passed = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_passed++;
      else $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    mem_valid = 1'b1; mem_exc_flags = 9'h000;
    tick();
    cp0_we = 1'b0; mem_valid = 1'b0;
  endtask

  logic [31:0] v;
  bit          seen;

  initial begin
    resetn = 1'b0; stall = 9'h0; ext_int = 6'h0; mem_valid = 1'b0; mem_pc = 32'h0;
    mem_in_ds = 1'b0; mem_exc_flags = 9'h0; mem_fetch_va = 32'h0; mem_data_va = 32'h0;
    cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'h0; cp0_raddr = 5'd0;
    tick(); tick();

    // Power-on reset state
    push("rst_status", 32'h0040_0000); rd(5'd12, v); chk(v);
    push("rst_cause", 32'h0);          rd(5'd13, v); chk(v);
    push("rst_count", 32'h0);          rd(5'd9, v);  chk(v);
    push("rst_epc", 32'h0);            chk(cp0_epc_o);
    push("rst_exctype", 32'h0);        chk(excepttype_o);
    push("rst_ti", 32'h0);             chk({31'd0, timer_int_o});
    resetn = 1'b1;
    tick();

    // Load some state, then pull reset mid-cycle
    mtc0(5'd14, 32'h1234_5678);
    push("mtc0_epc", 32'h1234_5678); chk(cp0_epc_o);
    mtc0(5'd12, 32'hffff_ffff);
    push("mtc0_status_mask", 32'h0040_ff03); rd(5'd12, v); chk(v);
    mtc0(5'd13, 32'hffff_ffff);
    push("mtc0_cause_mask", 32'h0000_0300); rd(5'd13, v); chk(v);
    mem_valid = 1'b1; #1;
    push("exl_masks_int", 32'h0); chk(excepttype_o);
    mem_valid = 1'b0;
    #2 resetn = 1'b0; #1;
    push("midrst_epc", 32'h0);            chk(cp0_epc_o);
    push("midrst_status", 32'h0040_0000); rd(5'd12, v); chk(v);
    push("midrst_cause", 32'h0);          rd(5'd13, v); chk(v);
    push("midrst_exctype", 32'h0);        chk(excepttype_o);
    tick(); resetn = 1'b1; tick();

    // Invalid MEM slot hides its flags
    mem_valid = 1'b0; mem_exc_flags = 9'h010; #1;
    push("invalid_no_exc", 32'h0); chk(excepttype_o);

    // syscall outside a delay slot
    mem_valid = 1'b1; mem_pc = 32'hbfc0_0100; mem_in_ds = 1'b0; mem_exc_flags = 9'h010; #1;
    push("sys_type", 32'h8); chk(excepttype_o);
    tick(); mem_valid = 1'b0; mem_exc_flags = 9'h0;
    push("sys_epc", 32'hbfc0_0100);    chk(cp0_epc_o);
    push("sys_cause", 32'h0000_0020);  rd(5'd13, v); chk(v);
    push("sys_status", 32'h0040_0002); rd(5'd12, v); chk(v);

    // ov+sys+ri in a delay slot: ri wins, EPC backs up to the branch
    mtc0(5'd12, 32'h0);
    mem_valid = 1'b1; mem_pc = 32'h8000_0010; mem_in_ds = 1'b1; mem_exc_flags = 9'h016; #1;
    push("ri_type", 32'ha); chk(excepttype_o);
    tick(); mem_valid = 1'b0; mem_exc_flags = 9'h0; mem_in_ds = 1'b0;
    push("ri_epc", 32'h8000_000c);   chk(cp0_epc_o);
    push("ri_cause", 32'h8000_0028); rd(5'd13, v); chk(v);

    // ades with a coincident mtc0 EPC that must be dropped
    mtc0(5'd12, 32'h0);
    mem_valid = 1'b1; mem_pc = 32'h8000_0100; mem_exc_flags = 9'h100; mem_data_va = 32'h0000_1003;
    cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'hdead_beef; #1;
    push("ades_type", 32'h5); chk(excepttype_o);
    tick(); mem_valid = 1'b0; mem_exc_flags = 9'h0; cp0_we = 1'b0;
    push("ades_badva", 32'h0000_1003); rd(5'd8, v);  chk(v);
    push("ades_cause", 32'h0000_0014); rd(5'd13, v); chk(v);
    push("ades_epc", 32'h8000_0100);   chk(cp0_epc_o);

    // Nested bp while EXL=1: ExcCode updates, EPC does not
    mem_valid = 1'b1; mem_pc = 32'h8000_0300; mem_in_ds = 1'b1; mem_exc_flags = 9'h020; #1;
    push("bp_type", 32'h9); chk(excepttype_o);
    tick(); mem_valid = 1'b0; mem_exc_flags = 9'h0; mem_in_ds = 1'b0;
    push("nested_epc", 32'h8000_0100);   chk(cp0_epc_o);
    push("nested_cause", 32'h0000_0024); rd(5'd13, v); chk(v);

    // Stalled mtc0 is ignored, then eret returns to EPC
    mtc0(5'd14, 32'h8000_0200);
    push("epc_write", 32'h8000_0200); chk(cp0_epc_o);
    stall = 9'h020;
    mtc0(5'd14, 32'h1111_1111);
    stall = 9'h000;
    push("stalled_mtc0", 32'h8000_0200); chk(cp0_epc_o);
    mem_valid = 1'b1; mem_exc_flags = 9'h040; #1;
    push("eret_type", 32'he); chk(excepttype_o);
    push("eret_epc", 32'h8000_0200); chk(cp0_epc_o);
    tick(); mem_valid = 1'b0; mem_exc_flags = 9'h0;
    push("eret_status", 32'h0040_0000); rd(5'd12, v); chk(v);

    // Timer interrupt
    mtc0(5'd12, 32'h0000_8001);
    push("tmr_status", 32'h0040_8001); rd(5'd12, v); chk(v);
    mtc0(5'd11, 32'h4);
    mtc0(5'd9, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (timer_int_o) seen = 1'b1;
      else tick();
    end
    push("tmr_seen", 32'h1); chk({31'd0, seen});
    push("tmr_count", 32'h4); rd(5'd9, v); chk(v);
    mem_valid = 1'b1; mem_pc = 32'h8000_0400; mem_exc_flags = 9'h0;
    tick();
    push("int_type", 32'h1); chk(excepttype_o);
    tick(); mem_valid = 1'b0;
    push("int_status", 32'h0040_8003); rd(5'd12, v); chk(v);
    push("int_cause", 32'h4000_8000);  rd(5'd13, v); chk(v);
    push("int_epc", 32'h8000_0400);    chk(cp0_epc_o);
    mtc0(5'd11, 32'h0000_0100);
    push("cmp_clears_ti", 32'h0); chk({31'd0, timer_int_o});

    // Hardware interrupt line lands in IP2
    ext_int = 6'h01;
    tick();
    rd(5'd13, v);
    push("ext_ip2", 32'h0000_0400); chk(v & 32'h0000_0400);
    ext_int = 6'h00;

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
